// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives comparator y and binary-searches
// the external x value. Optional macro SAR_SEARCH_EARLY_EXIT_EN ends the search on an equal hit.
module sar_search_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic [WIDTH-1:0] cmp_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      y_q     <= y_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    y_d     = y_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    trial   = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          y_d            = '0;
          y_d[WIDTH-1]   = 1'b1;
          k_d            = KW'(WIDTH-1);
          busy_d         = 1'b1;
          err_d          = 1'b0;
          state_d        = SETTLE;
        end
      end
      SETTLE: state_d = SAMPLE;
      SAMPLE: begin
        if (!$onehot({cmp_g, cmp_l, cmp_e})) begin
          res_d   = y_q;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        else if (cmp_e) begin
          res_d   = y_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`endif
        else begin
          // x below the trial means this bit overshoots; equal/greater keeps it
          if (cmp_l) trial[k_q] = 1'b0;
          if (k_q == '0) begin
            res_d   = trial;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            y_d                 = trial;
            y_d[k_q - KW'(1)]   = 1'b1;
            k_d                 = k_q - KW'(1);
            state_d             = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmp_y  = y_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl (WIDTH=8): behavioural comparator, vector table,
// plus hand sequences for held start, mid-search reset and back-to-back searches.
module tb_sar_search_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic         cmp_g, cmp_l, cmp_e;
  logic [W-1:0] cmp_y, result;
  logic         busy, done, err;

  logic [W-1:0] x_r;
  logic         force_bad;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  assign cmp_g = force_bad ? 1'b1 : (x_r > cmp_y);
  assign cmp_l = force_bad ? 1'b1 : (x_r < cmp_y);
  assign cmp_e = force_bad ? 1'b0 : (x_r == cmp_y);

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e),
    .cmp_y(cmp_y), .busy(busy), .done(done), .result(result), .err(err)
  );

  typedef struct {
    logic [W-1:0] x;
    int           fs;       // 1-based SAMPLE index to corrupt, 0 = none
    logic [W-1:0] exp_res;
    logic         exp_err;
    int           exp_lat;
    logic         chk_seq;
  } vec_t;

  vec_t vecs[7];
  logic [W-1:0] seq_a5[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected done latency for a well-behaved comparator.
  function automatic int clean_lat(input logic [W-1:0] x);
    int lat;
    lat = 2 * W;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    for (int b = W - 1; b >= 0; b--)
      if (x[b]) lat = 2 * (W - b);
`endif
    return lat;
  endfunction

  // Pulses start, counts edges until done; called at #1 after an edge.
  task automatic run_vec(input string name, input vec_t v);
    int c;
    x_r   = v.x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    chk({name, " busy_on_start"}, busy, 1);
    while (!done && c < 40) begin
      if (v.chk_seq && (c % 2 == 0) && c < 2 * W)
        chk($sformatf("%s cmp_y[%0d]", name, c / 2), cmp_y, seq_a5[c / 2]);
      force_bad = (v.fs != 0) && (c == 2 * v.fs - 1);
      @(posedge clk); #1;
      force_bad = 1'b0;
      c++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, expected %0d", name, c, v.exp_lat);
      return;
    end
    chk({name, " latency"}, c, v.exp_lat);
    chk({name, " result"}, result, v.exp_res);
    chk({name, " err"}, err, v.exp_err);
    chk({name, " busy_at_done"}, busy, 0);
  endtask

  initial begin
    seq_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vecs[0] = '{8'hA5, 0, 8'hA5, 1'b0, clean_lat(8'hA5), 1'b1};
    vecs[1] = '{8'h00, 0, 8'h00, 1'b0, clean_lat(8'h00), 1'b0};
    vecs[2] = '{8'hFF, 0, 8'hFF, 1'b0, clean_lat(8'hFF), 1'b0};
    vecs[3] = '{8'h80, 0, 8'h80, 1'b0, clean_lat(8'h80), 1'b0};
    vecs[4] = '{8'h01, 0, 8'h01, 1'b0, clean_lat(8'h01), 1'b0};
    vecs[5] = '{8'h3C, 3, 8'h20, 1'b1, 6,                1'b0};
    vecs[6] = '{8'h5A, 0, 8'h5A, 1'b0, clean_lat(8'h5A), 1'b0};

    rst = 1'b1; start = 1'b0; x_r = '0; force_bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset cmp_y", cmp_y, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
    end

    // Start held high through a search, then reset mid-search at cycle 7.
    x_r   = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 6) chk("held_start cmp_y", cmp_y, 8'h30);
    end
    chk("held_start busy", busy, 1);
    chk("held_start done", done, 0);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("midrst cmp_y", cmp_y, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst result", result, 0);
    chk("midrst err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst stays idle", busy, 0);
    run_vec("post_rst", '{8'h5A, 0, 8'h5A, 1'b0, clean_lat(8'h5A), 1'b0});

    // Back-to-back: second start lands in the done cycle of the first.
    @(posedge clk); #1;
    run_vec("b2b_first", '{8'hA5, 0, 8'hA5, 1'b0, clean_lat(8'hA5), 1'b0});
    run_vec("b2b_second", '{8'h3C, 0, 8'h3C, 1'b0, clean_lat(8'h3C), 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation search controller that drives the operand of a magnitude comparator and consumes its greater/less/equal outputs. It recovers an unknown WIDTH-bit value, which is applied externally to comparator input x, by binary search over the comparator's y input. It is the initiator end of the comparator interface: it generates y, then samples g/l/e.

## Interface
- WIDTH, default 8: operand width in bits; legal range 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a search; sampled only in IDLE.
- cmp_g  in  1  comparator "x > y".
- cmp_l  in  1  comparator "x < y".
- cmp_e  in  1  comparator "x == y".
- cmp_y  out  WIDTH  registered trial value; drives comparator y.
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  single-cycle completion pulse.
- result  out  WIDTH  recovered value; valid and held from done until the next accepted start.
- err  out  1  comparator response was not one-hot; valid with done.

## Operation
- States: IDLE, SETTLE, SAMPLE.
- IDLE, start=1: cmp_y <= 1<<(WIDTH-1), bit index k <= WIDTH-1, busy <= 1, err <= 0, next state SETTLE. start=0: stay in IDLE.
- SETTLE: one cycle for the combinational comparator to settle; next state SAMPLE.
- SAMPLE sequence:
  - Check {cmp_g,cmp_l,cmp_e}. If it is not exactly one-hot: result <= cmp_y, err <= 1, done <= 1, busy <= 0, next state IDLE.
  - Otherwise compute trial t = cmp_l ? cmp_y with bit k cleared : cmp_y.
  - If k==0: result <= t, done <= 1, busy <= 0, next state IDLE.
  - Otherwise: cmp_y <= t with bit k-1 set, k <= k-1, next state SETTLE.
- result equals the x value for any x in 0..2^WIDTH-1 when the comparator behaves correctly. No carry or overflow is possible because only bit set and bit clear operations are used.
- start is ignored while busy=1. There is no queueing.
- Reset at any point, including mid-search, sets state IDLE and all outputs to 0 on that edge.
- cmp_y holds its last value in IDLE.

## Timing
- Reset values: cmp_y=0, busy=0, done=0, result=0, err=0, state IDLE.
- start is sampled at edge N. busy=1 and cmp_y=MSB-only are visible after edge N.
- Each bit takes two edges (SETTLE, SAMPLE). The sample for bit k occurs at edge N+2·(WIDTH−k).
- Full search: done is high for exactly the one cycle following edge N+2·WIDTH. busy falls at that same edge.
- Back-to-back operation: start may be asserted during the done cycle. It is accepted at the next edge, because the state is already IDLE.
- An error abort at bit k asserts done after edge N+2·(WIDTH−k).
- cmp_g/l/e are sampled only in SAMPLE. Their values in other states are don't-care.

## Configuration
- Macro: SAR_SEARCH_EARLY_EXIT_EN.
- Defined: in SAMPLE, a valid one-hot response with cmp_e=1 ends the search immediately: result <= cmp_y, done <= 1, next state IDLE. Latency becomes 2·(WIDTH−k) cycles for a hit at bit k.
- Undefined: cmp_e is used only in the one-hot check. It is treated like cmp_g, so the bit is kept. Every error-free search takes exactly 2·WIDTH cycles.
- The result value is identical in both builds for error-free searches.

## Test plan
- WIDTH=8, macro undefined, x=0xA5, pulse start: cmp_y sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done 16 cycles after start; result=0xA5, err=0.
- Boundaries, macro undefined: x=0x00 gives result=0x00 and x=0xFF gives result=0xFF, each with done at cycle 16.
- Macro defined, x=0x80: cmp_e=1 at the first SAMPLE; done 2 cycles after start; result=0x80. With x=0x01, done at cycle 16 and result=0x01.
- Force cmp_g=cmp_l=1 at the third SAMPLE, x=0x3C: done at cycle 6, err=1, result=0x20.
- start held high during a search has no effect. rst asserted at cycle 7: next edge gives all outputs 0 and state IDLE. A new start with x=0x5A then completes with result=0x5A.
- Back-to-back: start asserted in the done cycle is accepted, busy stays effectively continuous, and the second result is correct.
